// File: rtl/cc_matrix_scan.sv
// cc_matrix_scan: 7-row x 8-column LED matrix scanner.
// Each row goes through LATCH (1 cycle, rows off), then SHOW (PRESCALE_MAX
// cycles, one row lit), then optionally BLANK (BLANK_CYCLES cycles, all off).
// All seven row patterns are snapshotted once per frame, at the row-0 LATCH,
// so a frame never mixes old and new data.
// Optional feature macro: CC_MATRIX_SCAN_GHOSTBLANK_EN adds the BLANK state
// between rows to suppress ghosting. Without it, SHOW goes straight to LATCH.
//
//   state | meaning
//   IDLE  | scan held, display dark, waiting for enable
//   LATCH | one cycle with rows off; column data loaded for the current row
//   SHOW  | current row lit for PRESCALE_MAX cycles
//   BLANK | all rows dark for BLANK_CYCLES cycles (ghost-blank build only)
module cc_matrix_scan #(
  parameter int unsigned PRESCALE_MAX = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic       CC_MATRIX_SCAN_CLOCK_50,
  input  logic       CC_MATRIX_SCAN_RESET_InHigh,
  input  logic       CC_MATRIX_SCAN_enable_InHigh,
  input  logic [7:0] CC_MATRIX_SCAN_data1_InBUS,
  input  logic [7:0] CC_MATRIX_SCAN_data2_InBUS,
  input  logic [7:0] CC_MATRIX_SCAN_data3_InBUS,
  input  logic [7:0] CC_MATRIX_SCAN_data4_InBUS,
  input  logic [7:0] CC_MATRIX_SCAN_data5_InBUS,
  input  logic [7:0] CC_MATRIX_SCAN_data6_InBUS,
  input  logic [7:0] CC_MATRIX_SCAN_data7_InBUS,
  output logic [6:0] CC_MATRIX_SCAN_row_OutLow,
  output logic [7:0] CC_MATRIX_SCAN_col_OutBUS,
  output logic       CC_MATRIX_SCAN_frameDone_OutHigh
);

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
`ifdef CC_MATRIX_SCAN_GHOSTBLANK_EN
    SHOW,
    BLANK
`else
    SHOW
`endif
  } state_t;

  localparam logic [19:0] SHOW_LOAD  = 20'(PRESCALE_MAX - 1);
  localparam logic [6:0]  ROWS_OFF   = 7'h7F;

  // Out-of-range parameters leave a visibly named scope in the elaborated design.
  if (BLANK_CYCLES < 1 || BLANK_CYCLES > 255) begin : g_blank_cycles_out_of_range
  end
  if (PRESCALE_MAX < 1 || PRESCALE_MAX > 20'hFFFFF) begin : g_prescale_out_of_range
  end

  state_t      state, state_nxt;
  logic [2:0]  row_idx, row_idx_nxt;
  logic [19:0] cnt, cnt_nxt;
  logic [7:0]  snap [7];
  logic        snap_we;
  logic [7:0]  data_bus [7];
  logic [6:0]  row_nxt;
  logic [7:0]  col_nxt;
  logic        done_nxt;
  logic [6:0]  row_lit;
  logic [2:0]  row_inc;

  assign data_bus[0] = CC_MATRIX_SCAN_data1_InBUS;
  assign data_bus[1] = CC_MATRIX_SCAN_data2_InBUS;
  assign data_bus[2] = CC_MATRIX_SCAN_data3_InBUS;
  assign data_bus[3] = CC_MATRIX_SCAN_data4_InBUS;
  assign data_bus[4] = CC_MATRIX_SCAN_data5_InBUS;
  assign data_bus[5] = CC_MATRIX_SCAN_data6_InBUS;
  assign data_bus[6] = CC_MATRIX_SCAN_data7_InBUS;

  assign row_lit = ~(7'd1 << row_idx);
  assign row_inc = (row_idx == 3'd6) ? 3'd0 : 3'(row_idx + 3'd1);

  // State, index, dwell counter and registered outputs.
  always_ff @(posedge CC_MATRIX_SCAN_CLOCK_50 or posedge CC_MATRIX_SCAN_RESET_InHigh) begin
    if (CC_MATRIX_SCAN_RESET_InHigh) begin
      state                            <= IDLE;
      row_idx                          <= 3'd0;
      cnt                              <= 20'd0;
      CC_MATRIX_SCAN_row_OutLow        <= ROWS_OFF;
      CC_MATRIX_SCAN_col_OutBUS        <= 8'h00;
      CC_MATRIX_SCAN_frameDone_OutHigh <= 1'b0;
    end else begin
      state                            <= state_nxt;
      row_idx                          <= row_idx_nxt;
      cnt                              <= cnt_nxt;
      CC_MATRIX_SCAN_row_OutLow        <= row_nxt;
      CC_MATRIX_SCAN_col_OutBUS        <= col_nxt;
      CC_MATRIX_SCAN_frameDone_OutHigh <= done_nxt;
    end
  end

  // Frame snapshot, refreshed only at the row-0 LATCH.
  always_ff @(posedge CC_MATRIX_SCAN_CLOCK_50 or posedge CC_MATRIX_SCAN_RESET_InHigh) begin
    if (CC_MATRIX_SCAN_RESET_InHigh) begin
      for (int i = 0; i < 7; i++) snap[i] <= 8'h00;
    end else if (snap_we) begin
      for (int i = 0; i < 7; i++) snap[i] <= data_bus[i];
    end
  end

  // Next-state and next-output decode; enable low overrides everything.
  always_comb begin
    state_nxt   = state;
    row_idx_nxt = row_idx;
    cnt_nxt     = cnt;
    row_nxt     = ROWS_OFF;
    col_nxt     = CC_MATRIX_SCAN_col_OutBUS;
    done_nxt    = 1'b0;
    snap_we     = 1'b0;

    if (!CC_MATRIX_SCAN_enable_InHigh) begin
      state_nxt   = IDLE;
      row_idx_nxt = 3'd0;
      cnt_nxt     = 20'd0;
      col_nxt     = 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt   = LATCH;
          row_idx_nxt = 3'd0;
          col_nxt     = 8'h00;
        end
        LATCH: begin
          state_nxt = SHOW;
          cnt_nxt   = SHOW_LOAD;
          row_nxt   = row_lit;
          if (row_idx == 3'd0) begin
            snap_we = 1'b1;
            col_nxt = data_bus[0];
          end else begin
            col_nxt = snap[row_idx];
          end
        end
        SHOW: begin
          if (cnt == 20'd0) begin
            row_idx_nxt = row_inc;
`ifdef CC_MATRIX_SCAN_GHOSTBLANK_EN
            state_nxt = BLANK;
            cnt_nxt   = 20'(BLANK_CYCLES - 1);
            col_nxt   = 8'h00;
`else
            state_nxt = LATCH;
            done_nxt  = (row_idx == 3'd6);
`endif
          end else begin
            cnt_nxt = cnt - 20'd1;
            row_nxt = row_lit;
          end
        end
`ifdef CC_MATRIX_SCAN_GHOSTBLANK_EN
        BLANK: begin
          col_nxt = 8'h00;
          if (cnt == 20'd0) begin
            state_nxt = LATCH;
            done_nxt  = (row_idx == 3'd0);
          end else begin
            cnt_nxt = cnt - 20'd1;
          end
        end
`endif
        default: begin
          state_nxt   = IDLE;
          row_idx_nxt = 3'd0;
          cnt_nxt     = 20'd0;
          col_nxt     = 8'h00;
        end
      endcase
    end
  end

endmodule

// File: doc/cc_matrix_scan.md
CC_MATRIX_SCAN -- requirements
Module: CC_MATRIX_SCAN

Interface
REQ-001 The block SHALL have parameter PRESCALE_MAX, default 50000, meaning clock cycles each row stays lit in SHOW (legal range 1..2^20-1).
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 16, meaning all-rows-off cycles between rows (legal range 1..255, used only with CC_MATRIX_SCAN_GHOSTBLANK_EN).
REQ-003 CC_MATRIX_SCAN_CLOCK_50  input  1  single system clock; all state changes on its rising edge.
REQ-004 CC_MATRIX_SCAN_RESET_InHigh  input  1  asynchronous, active-high reset.
REQ-005 CC_MATRIX_SCAN_enable_InHigh  input  1  1 = scan running, 0 = display blanked and scan held.
REQ-006 CC_MATRIX_SCAN_data1_InBUS .. CC_MATRIX_SCAN_data7_InBUS  input  8 each  row patterns 1..7 from the row-select mux stage; bit7 = leftmost column.
REQ-007 CC_MATRIX_SCAN_row_OutLow  output  7  one-hot active-low row drive; bit k lights row k+1.
REQ-008 CC_MATRIX_SCAN_col_OutBUS  output  8  active-high column drive for the lit row.
REQ-009 CC_MATRIX_SCAN_frameDone_OutHigh  output  1  one-cycle pulse at each completed frame.

Function
REQ-010 The block SHALL implement states IDLE, LATCH, SHOW, BLANK, plus a 3-bit row index (0..6) and a 20-bit dwell counter.
REQ-011 IDLE: row_OutLow = 7'b1111111, col_OutBUS = 0; on enable = 1 the block SHALL enter LATCH with row index 0 on the next edge.
REQ-012 LATCH (1 cycle): if row index = 0, all seven data buses SHALL be captured into a 7x8 snapshot; col_OutBUS SHALL load the snapshot entry (or, for row 0, the just-captured value) for the current row; rows SHALL stay off.
REQ-013 SHOW: row_OutLow bit [row index] SHALL be 0 and all others 1 for exactly PRESCALE_MAX cycles, with col_OutBUS held constant.
REQ-014 After SHOW the block SHALL enter BLANK when CC_MATRIX_SCAN_GHOSTBLANK_EN is defined, otherwise LATCH directly.
REQ-015 BLANK: rows all off and col_OutBUS = 0 for exactly BLANK_CYCLES cycles, then LATCH.
REQ-016 On leaving SHOW/BLANK the row index SHALL increment, wrapping 6 -> 0.
REQ-017 frameDone_OutHigh SHALL be 1 for exactly the first LATCH cycle following the row-6 wrap, and 0 otherwise (never on the first frame after IDLE).
REQ-018 Data bus changes after a frame's row-0 LATCH SHALL NOT affect the display until the next frame's row-0 LATCH (no tearing).
REQ-019 Frame period SHALL be 7*(1+PRESCALE_MAX+BLANK_CYCLES) cycles with the macro defined and 7*(1+PRESCALE_MAX) without.
REQ-020 enable = 0 in any state SHALL force IDLE on the next edge with row index 0, counter 0 and frameDone 0; enable has priority over dwell-count completion in the same cycle.
REQ-021 At no cycle SHALL more than one row_OutLow bit be 0.
REQ-022 All outputs SHALL be registered.

Reset
REQ-023 Reset asserted SHALL immediately (asynchronously) force: state IDLE, row index 0, counter 0, snapshot all 0, row_OutLow = 7'b1111111, col_OutBUS = 8'h00, frameDone_OutHigh = 0.
REQ-024 Reset asserted mid-SHOW SHALL blank the lit row without waiting for a clock edge; after release with enable = 1, the first lit row SHALL be row 1.

Configuration
REQ-025 Macro CC_MATRIX_SCAN_GHOSTBLANK_EN defined: the BLANK state SHALL exist per REQ-015; undefined: BLANK SHALL be absent, BLANK_CYCLES SHALL be ignored, and SHOW -> LATCH directly.

Verification
REQ-026 Reset with enable = 1 held: row_OutLow = 7'h7F, col = 0 during reset; first LATCH one cycle after release, row 1 lit on the cycle after that.
REQ-027 PRESCALE_MAX=4, BLANK_CYCLES=2, macro on, data1=8'hA5: col=8'hA5 and row_OutLow=7'b1111110 for exactly 4 cycles, then 2 cycles of 7'h7F and col 0; frame = 49 cycles.
REQ-028 Same, but data3 changed from 8'h0F to 8'hF0 while row 2 is SHOWing: row 3 shows 8'h0F this frame and 8'hF0 the next frame.
REQ-029 Run two frames: frameDone pulses once, 1 cycle wide, at cycle 49 after the first LATCH; row order 1..7 then wraps to 1.
REQ-030 enable dropped during row 4 SHOW: next edge row_OutLow = 7'h7F, col = 0, no frameDone; enable reasserted -> row 1 displayed next.
REQ-031 Macro off, PRESCALE_MAX=4: no all-off gaps other than the LATCH cycle, frame = 35 cycles, one-hot property holds every cycle.
